// File: rtl/lnrv_ifu_prefetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : lnrv_ifu_prefetch_if
//  Brief    : Core-bus fetch channel plus EXU instruction handshake
//  Revision : 1.0
// ============================================================================
interface lnrv_ifu_prefetch_if;
   logic        ifu_cmd_vld;
   logic        ifu_cmd_rdy;
   logic        ifu_cmd_write;
   logic [31:0] ifu_cmd_addr;
   logic [31:0] ifu_cmd_wdata;
   logic [3:0]  ifu_cmd_wstrb;
   logic [2:0]  ifu_cmd_size;
   logic        ifu_rsp_vld;
   logic        ifu_rsp_rdy;
   logic [31:0] ifu_rsp_rdata;
   logic        ifu_rsp_err;
   logic        ifu_ir_vld;
   logic        ifu_ir_rdy;
   logic [31:0] ifu_pc;
   logic [31:0] ifu_ir;
   logic        ifu_misalgn;
   logic        ifu_buserr;
   logic        ifu_prdt_taken;

   modport master (
      output ifu_cmd_vld, ifu_cmd_write, ifu_cmd_addr, ifu_cmd_wdata, ifu_cmd_wstrb, ifu_cmd_size,
      input  ifu_cmd_rdy,
      input  ifu_rsp_vld, ifu_rsp_rdata, ifu_rsp_err,
      output ifu_rsp_rdy,
      output ifu_ir_vld, ifu_pc, ifu_ir, ifu_misalgn, ifu_buserr, ifu_prdt_taken,
      input  ifu_ir_rdy
   );

   modport slave (
      input  ifu_cmd_vld, ifu_cmd_write, ifu_cmd_addr, ifu_cmd_wdata, ifu_cmd_wstrb, ifu_cmd_size,
      output ifu_cmd_rdy,
      output ifu_rsp_vld, ifu_rsp_rdata, ifu_rsp_err,
      input  ifu_rsp_rdy,
      input  ifu_ir_vld, ifu_pc, ifu_ir, ifu_misalgn, ifu_buserr, ifu_prdt_taken,
      output ifu_ir_rdy
   );
endinterface
`default_nettype wire

// File: rtl/lnrv_ifu_prefetch.sv
`default_nettype none
// ============================================================================
//  Module   : lnrv_ifu_prefetch
//  Brief    : Multi-outstanding instruction prefetcher with static prediction
//  Revision : 1.0
// ============================================================================
module lnrv_ifu_prefetch #(
   parameter int FIFO_DEPTH = 4,
   parameter int OUTS_MAX   = 2,
   parameter int BPU_EN     = 1
) (
   input  wire logic        clk,
   input  wire logic        reset_n,
   input  wire logic [31:0] reset_vector,
   input  wire logic        pipe_flush_req,
   output logic             pipe_flush_ack,
   input  wire logic [31:0] pipe_flush_pc_op1,
   input  wire logic [31:0] pipe_flush_pc_op2,
   input  wire logic        pipe_halt_req,
   output logic             pipe_halt_ack,
   lnrv_ifu_prefetch_if.master ifu
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int TW = (OUTS_MAX > 1) ? $clog2(OUTS_MAX) : 1;
   localparam logic [CW:0]   c_DEPTH    = (CW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] c_OUTS_MAX = CW'(OUTS_MAX);
   localparam logic [TW-1:0] c_TAG_LAST = TW'(OUTS_MAX - 1);

   logic          r_boot;
   logic          r_stall;
   logic [31:0]   r_fetch_pc;
   logic [CW-1:0] r_outs;
   logic [CW-1:0] r_kill;
   logic [CW-1:0] r_cnt;
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [TW-1:0] r_tag_wptr;
   logic [TW-1:0] r_tag_rptr;
   logic [31:0]   r_tag     [OUTS_MAX];
   logic [31:0]   r_fifo_pc [FIFO_DEPTH];
   logic [31:0]   r_fifo_ir [FIFO_DEPTH];
   logic [2:0]    r_fifo_fl [FIFO_DEPTH];

   logic [31:0]   w_rd;
   logic [31:0]   w_tag;
   logic [31:0]   w_imm;
   logic          w_rsp, w_keep, w_kill_rsp, w_jal, w_bxx, w_taken;
   logic          w_misalgn, w_room, w_cmd_vld, w_issue, w_mis_push, w_push, w_pop;
   logic [CW-1:0] w_outs_nxt;

   assign w_rd       = ifu.ifu_rsp_rdata;
   assign w_tag      = r_tag[r_tag_rptr];
   // Responses with nothing outstanding (e.g. stale after reset) are ignored.
   assign w_rsp      = ifu.ifu_rsp_vld & (r_outs != '0);
   assign w_kill_rsp = w_rsp & (r_kill != '0);
   assign w_keep     = w_rsp & (r_kill == '0);
   assign w_jal      = (w_rd[6:0] == 7'b1101111);
   assign w_bxx      = (w_rd[6:0] == 7'b1100011);
   assign w_taken    = (BPU_EN != 0) & w_keep & (w_jal | (w_bxx & w_rd[31]));
   assign w_imm      = w_jal ? {{12{w_rd[31]}}, w_rd[19:12], w_rd[20], w_rd[30:21], 1'b0}
                             : {{20{w_rd[31]}}, w_rd[7], w_rd[30:25], w_rd[11:8], 1'b0};

   assign w_misalgn  = |r_fetch_pc[1:0];
   // Reserve buffer space for every read in flight so a response always fits.
   assign w_room     = ({1'b0, r_cnt} + {1'b0, r_outs}) < c_DEPTH;
   assign w_cmd_vld  = ~r_boot & ~pipe_halt_req & ~pipe_flush_req & ~r_stall & ~w_misalgn &
                       (r_outs < c_OUTS_MAX) & w_room & ~w_taken;
   assign w_issue    = w_cmd_vld & ifu.ifu_cmd_rdy;
   assign w_mis_push = ~r_boot & ~pipe_flush_req & ~r_stall & w_misalgn & (r_outs == '0) &
                       ({1'b0, r_cnt} != c_DEPTH);
   assign w_push     = ~pipe_flush_req & (w_keep | w_mis_push);
   assign w_pop      = (r_cnt != '0) & ifu.ifu_ir_rdy;
   assign w_outs_nxt = r_outs + CW'(w_issue) - CW'(w_rsp);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_boot     <= 1'b1;
         r_stall    <= 1'b0;
         r_fetch_pc <= '0;
         r_outs     <= '0;
         r_kill     <= '0;
         r_cnt      <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_tag_wptr <= '0;
         r_tag_rptr <= '0;
      end else begin
         r_outs <= w_outs_nxt;
         if (w_issue) r_tag_wptr <= (r_tag_wptr == c_TAG_LAST) ? '0 : r_tag_wptr + TW'(1);
         if (w_rsp)   r_tag_rptr <= (r_tag_rptr == c_TAG_LAST) ? '0 : r_tag_rptr + TW'(1);

         if (r_boot) begin
            r_boot     <= 1'b0;
            r_fetch_pc <= reset_vector;
         end else if (pipe_flush_req) begin
            r_fetch_pc <= pipe_flush_pc_op1 + pipe_flush_pc_op2;
         end else if (w_taken) begin
            r_fetch_pc <= w_tag + w_imm;
         end else if (w_issue) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
         end

         if (pipe_flush_req)  r_kill <= r_outs - CW'(w_rsp);
         else if (w_taken)    r_kill <= w_outs_nxt;
         else if (w_kill_rsp) r_kill <= r_kill - CW'(1);

         if (pipe_flush_req)                                   r_stall <= 1'b0;
         else if (w_mis_push | (w_keep & ifu.ifu_rsp_err))     r_stall <= 1'b1;

         if (pipe_flush_req) begin
            r_cnt  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_issue) r_tag[r_tag_wptr] <= r_fetch_pc;
      if (w_push) begin
         r_fifo_pc[r_wptr] <= w_keep ? w_tag : r_fetch_pc;
         r_fifo_ir[r_wptr] <= w_keep ? w_rd : 32'd0;
         r_fifo_fl[r_wptr] <= {w_taken, w_keep & ifu.ifu_rsp_err, ~w_keep};
      end
   end

   assign pipe_flush_ack     = pipe_flush_req;
   assign pipe_halt_ack      = pipe_halt_req & (r_outs == '0);

   assign ifu.ifu_cmd_vld    = w_cmd_vld;
   assign ifu.ifu_cmd_write  = 1'b0;
   assign ifu.ifu_cmd_addr   = {r_fetch_pc[31:2], 2'b00};
   assign ifu.ifu_cmd_wdata  = 32'd0;
   assign ifu.ifu_cmd_wstrb  = 4'd0;
   assign ifu.ifu_cmd_size   = 3'b010;
   assign ifu.ifu_rsp_rdy    = 1'b1;

   assign ifu.ifu_ir_vld     = (r_cnt != '0);
   assign ifu.ifu_pc         = r_fifo_pc[r_rptr];
   assign ifu.ifu_ir         = r_fifo_ir[r_rptr];
   assign ifu.ifu_misalgn    = r_fifo_fl[r_rptr][0];
   assign ifu.ifu_buserr     = r_fifo_fl[r_rptr][1];
   assign ifu.ifu_prdt_taken = r_fifo_fl[r_rptr][2];

endmodule
`default_nettype wire

// File: tb/tb_lnrv_ifu_prefetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lnrv_ifu_prefetch
//  Brief    : Directed bench for the prefetcher with a latency-programmable memory
//  Revision : 1.0
// ============================================================================
module tb_lnrv_ifu_prefetch;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] reset_vector = 32'h8000_0000;
   logic        pipe_flush_req = 1'b0;
   logic        pipe_flush_ack;
   logic [31:0] pipe_flush_pc_op1 = '0;
   logic [31:0] pipe_flush_pc_op2 = '0;
   logic        pipe_halt_req = 1'b0;
   logic        pipe_halt_ack;

   lnrv_ifu_prefetch_if bus ();

   lnrv_ifu_prefetch #(.FIFO_DEPTH(4), .OUTS_MAX(2), .BPU_EN(1)) u_dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .reset_vector      (reset_vector),
      .pipe_flush_req    (pipe_flush_req),
      .pipe_flush_ack    (pipe_flush_ack),
      .pipe_flush_pc_op1 (pipe_flush_pc_op1),
      .pipe_flush_pc_op2 (pipe_flush_pc_op2),
      .pipe_halt_req     (pipe_halt_req),
      .pipe_halt_ack     (pipe_halt_ack),
      .ifu               (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ir;
      logic        mis;
      logic        be;
      logic        pt;
   } ent_t;

   req_t        pend[$];
   logic [31:0] cmd_log[$];
   ent_t        exu_log[$];
   int          cyc = 0;
   int          lat = 1;
   bit          hold = 1'b0;
   logic [31:0] err_addr = 32'hFFFF_FFF0;
   int          n_chk = 0;
   int          n_fail = 0;

   function automatic logic [31:0] memrd(input logic [31:0] a);
      case (a)
         32'h0000_0100: memrd = 32'h0080_006F;   // jal x0, +8
         32'h0000_010C: memrd = 32'hFE00_0CE3;   // beq x0, x0, -8
         default:       memrd = {a[24:0], 7'h13};
      endcase
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   task automatic do_flush(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      pipe_flush_pc_op1 = a;
      pipe_flush_pc_op2 = b;
      pipe_flush_req    = 1'b1;
      pipe_halt_req     = 1'b0;
      #2;
      check_eq("flush_ack", {31'd0, pipe_flush_ack}, 32'd1);
      @(negedge clk);
      pipe_flush_req = 1'b0;
      cmd_log.delete();
      exu_log.delete();
   endtask

   task automatic wait_halt(input int max);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         #2;
         k++;
      end while (!pipe_halt_ack && k < max);
      check_eq("halt_ack", {31'd0, pipe_halt_ack}, 32'd1);
   endtask

   // Memory model: in-order responses after 'lat' cycles, plus EXU-side logging.
   initial begin : g_mem
      req_t r;
      bus.ifu_cmd_rdy   = 1'b1;
      bus.ifu_ir_rdy    = 1'b1;
      bus.ifu_rsp_vld   = 1'b0;
      bus.ifu_rsp_rdata = '0;
      bus.ifu_rsp_err   = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset_n) begin
            pend.delete();
            bus.ifu_rsp_vld = 1'b0;
            continue;
         end
         if (!hold && pend.size() > 0 && pend[0].due <= cyc) begin
            r = pend.pop_front();
            bus.ifu_rsp_vld   = 1'b1;
            bus.ifu_rsp_rdata = memrd(r.addr);
            bus.ifu_rsp_err   = (r.addr == err_addr);
         end else begin
            bus.ifu_rsp_vld   = 1'b0;
            bus.ifu_rsp_rdata = '0;
            bus.ifu_rsp_err   = 1'b0;
         end
         #1;
         if (bus.ifu_cmd_vld && bus.ifu_cmd_rdy) begin
            r.addr = bus.ifu_cmd_addr;
            r.due  = cyc + lat;
            pend.push_back(r);
            cmd_log.push_back(bus.ifu_cmd_addr);
         end
         if (bus.ifu_ir_vld && bus.ifu_ir_rdy && !pipe_flush_req)
            exu_log.push_back({bus.ifu_pc, bus.ifu_ir, bus.ifu_misalgn, bus.ifu_buserr, bus.ifu_prdt_taken});
      end
   end

   initial begin : g_watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : g_main
      int k;
      // Reset state
      step(2);
      check_eq("rst_ir_vld",    {31'd0, bus.ifu_ir_vld},  32'd0);
      check_eq("rst_cmd_vld",   {31'd0, bus.ifu_cmd_vld}, 32'd0);
      check_eq("rst_halt_ack",  {31'd0, pipe_halt_ack},  32'd0);
      check_eq("rst_flush_ack", {31'd0, pipe_flush_ack}, 32'd0);

      // Boot and sequential fetch
      @(negedge clk);
      reset_n = 1'b1;
      #2;
      check_eq("boot_cmd_vld", {31'd0, bus.ifu_cmd_vld}, 32'd0);
      k = 0;
      while (!bus.ifu_rsp_vld && k < 20) begin
         step(1);
         k++;
      end
      check_eq("first_rsp_seen", {31'd0, bus.ifu_rsp_vld}, 32'd1);
      check_eq("no_bypass", {31'd0, bus.ifu_ir_vld}, 32'd0);
      step(12);
      check_eq("seq_cmd0", cmd_log[0], 32'h8000_0000);
      check_eq("seq_cmd1", cmd_log[1], 32'h8000_0004);
      check_eq("seq_cmd2", cmd_log[2], 32'h8000_0008);
      check_eq("seq_exu0_pc", exu_log[0].pc, 32'h8000_0000);
      check_eq("seq_exu0_ir", exu_log[0].ir, memrd(32'h8000_0000));
      check_eq("seq_exu2_pc", exu_log[2].pc, 32'h8000_0008);
      check_eq("seq_exu2_ir", exu_log[2].ir, memrd(32'h8000_0008));
      @(negedge clk);
      pipe_halt_req = 1'b1;
      wait_halt(10);

      // Back-pressure: buffer fills to four entries
      @(negedge clk);
      bus.ifu_ir_rdy = 1'b0;
      do_flush(32'h0000_1000, 32'h0);
      step(15);
      check_eq("bp_ir_vld",  {31'd0, bus.ifu_ir_vld},  32'd1);
      check_eq("bp_cmd_vld", {31'd0, bus.ifu_cmd_vld}, 32'd0);
      check_eq("bp_cmd_cnt", cmd_log.size(), 32'd4);
      check_eq("bp_head_pc", bus.ifu_pc, 32'h0000_1000);
      @(negedge clk);
      bus.ifu_ir_rdy = 1'b1;
      step(10);
      check_eq("bp_resume_cmd", cmd_log[4], 32'h0000_1010);
      check_eq("bp_resume_exu", exu_log[4].pc, 32'h0000_1010);
      @(negedge clk);
      pipe_halt_req = 1'b1;
      wait_halt(10);

      // JAL +8 then backward branch to 0x104, with 2-cycle memory
      lat = 2;
      do_flush(32'h0000_0100, 32'h0);
      step(16);
      check_eq("bpu_cmd2", cmd_log[2], 32'h0000_0108);
      check_eq("bpu_cmd4", cmd_log[4], 32'h0000_0104);
      check_eq("bpu_exu0_ir", exu_log[0].ir, 32'h0080_006F);
      check_eq("bpu_exu0_pt", {31'd0, exu_log[0].pt}, 32'd1);
      check_eq("bpu_exu1_pc", exu_log[1].pc, 32'h0000_0108);
      check_eq("bpu_exu1_pt", {31'd0, exu_log[1].pt}, 32'd0);
      check_eq("bpu_exu2_pt", {31'd0, exu_log[2].pt}, 32'd1);
      check_eq("bpu_exu3_pc", exu_log[3].pc, 32'h0000_0104);

      // Flush with two reads held outstanding
      @(negedge clk);
      hold = 1'b1;
      step(4);
      do_flush(32'h0000_0200, 32'h0000_0004);
      @(negedge clk);
      hold = 1'b0;
      step(10);
      check_eq("fl_cmd0", cmd_log[0], 32'h0000_0204);
      check_eq("fl_exu0_pc", exu_log[0].pc, 32'h0000_0204);
      check_eq("fl_exu0_ir", exu_log[0].ir, memrd(32'h0000_0204));

      // Misaligned redirect
      do_flush(32'h0000_0200, 32'h0000_0002);
      step(12);
      check_eq("mis_cmd_cnt", cmd_log.size(), 32'd0);
      check_eq("mis_cmd_vld", {31'd0, bus.ifu_cmd_vld}, 32'd0);
      check_eq("mis_exu_cnt", exu_log.size(), 32'd1);
      check_eq("mis_exu_pc", exu_log[0].pc, 32'h0000_0202);
      check_eq("mis_exu_flag", {31'd0, exu_log[0].mis}, 32'd1);
      check_eq("mis_exu_ir", exu_log[0].ir, 32'd0);

      // Halt with two outstanding, second read errors
      @(negedge clk);
      hold = 1'b1;
      err_addr = 32'h0000_0304;
      do_flush(32'h0000_0300, 32'h0);
      step(4);
      @(negedge clk);
      pipe_halt_req = 1'b1;
      #2;
      check_eq("halt_busy", {31'd0, pipe_halt_ack}, 32'd0);
      @(negedge clk);
      hold = 1'b0;
      wait_halt(10);
      step(2);
      check_eq("err_exu_cnt", exu_log.size(), 32'd2);
      check_eq("err_exu0_be", {31'd0, exu_log[0].be}, 32'd0);
      check_eq("err_exu1_be", {31'd0, exu_log[1].be}, 32'd1);
      check_eq("err_exu1_pc", exu_log[1].pc, 32'h0000_0304);
      @(negedge clk);
      pipe_halt_req = 1'b0;
      cmd_log.delete();
      step(8);
      check_eq("err_stall", cmd_log.size(), 32'd0);

      // Reset in the middle of traffic
      do_flush(32'h0000_0400, 32'h0);
      step(3);
      @(negedge clk);
      reset_n = 1'b0;
      #2;
      check_eq("mrst_ir_vld",  {31'd0, bus.ifu_ir_vld},  32'd0);
      check_eq("mrst_cmd_vld", {31'd0, bus.ifu_cmd_vld}, 32'd0);
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
